// File: rtl/systolic_pkg.sv
// Shared types for the systolic tile sequencer: sequencer states and the
// per-row tag that travels alongside data to steer psum capture.
package systolic_pkg;

  localparam int unsigned DATAWIDTH_DEF = 8;
  localparam int unsigned ACCW_DEF      = 3 * DATAWIDTH_DEF;
  localparam int unsigned M_MAX_DEF     = 16;
  localparam int unsigned ROW_W         = $clog2(M_MAX_DEF);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    STREAM,
    DRAIN,
    OUTPUT,
    FINISH
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [ROW_W-1:0] row_idx;
  } tag_t;

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth register shift line (DEPTH >= 1) used for lane skew and tags.
module skew_delay_line #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/systolic_tile_sequencer.sv
// Tile controller for a weight-stationary systolic array: loads K weight tiles,
// skews M activation rows per tile, recirculates psums and returns result rows.
module systolic_tile_sequencer
  import systolic_pkg::*;
#(
  parameter int unsigned DATAWIDTH = DATAWIDTH_DEF,
  parameter int unsigned N_SIZE    = 2,
  parameter int unsigned ACCW      = 3 * DATAWIDTH,
  parameter int unsigned M_MAX     = M_MAX_DEF,
  parameter int unsigned K_MAX     = 16,
  parameter int unsigned B_OFS     = 0,
  parameter int unsigned C_LAT     = N_SIZE
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic [$clog2(M_MAX+1)-1:0]          cfg_m_rows,
  input  logic [$clog2(K_MAX+1)-1:0]          cfg_k_tiles,
  output logic                                busy,
  output logic                                done,
  input  logic                                wt_in_valid,
  output logic                                wt_in_ready,
  input  logic [N_SIZE*N_SIZE*DATAWIDTH-1:0]  wt_in,
  input  logic                                a_in_valid,
  output logic                                a_in_ready,
  input  logic [N_SIZE*DATAWIDTH-1:0]         a_in,
  output logic                                wt_en,
  output logic [N_SIZE*N_SIZE*DATAWIDTH-1:0]  wt_flat,
  output logic                                valid_in,
  output logic [N_SIZE*DATAWIDTH-1:0]         matrix_A,
  output logic [N_SIZE*ACCW-1:0]              matrix_B,
  input  logic [N_SIZE*ACCW-1:0]              matrix_C,
  output logic                                res_valid,
  input  logic                                res_ready,
  output logic [N_SIZE*ACCW-1:0]              res_data,
  output logic                                res_last
);

  localparam int unsigned MW   = $clog2(M_MAX+1);
  localparam int unsigned KW   = $clog2(K_MAX+1);
  localparam int unsigned PIPE = C_LAT + N_SIZE;

  state_t               state;
  logic [MW-1:0]        m_q, row_cnt, out_idx;
  logic [KW-1:0]        k_q, tile_q;
  logic [PIPE-1:0]      inflight;
  logic [ACCW-1:0]      psum_buf [M_MAX][N_SIZE];
  tag_t                 cap_tag [N_SIZE];
  tag_t                 iss_tag;
  logic                 a_fire;
  logic                 v_next;
  logic [ROW_W-1:0]     rd_idx;
  logic [N_SIZE*ACCW-1:0] rd_row;

  assign a_fire  = a_in_valid && a_in_ready;
  assign iss_tag = '{valid: a_fire, row_idx: ROW_W'(row_cnt)};

  // A row issued now occupies lane r of the array r+1 cycles later.
  always_comb begin
    v_next = a_fire;
    for (int i = 0; i < N_SIZE - 1; i++) v_next = v_next | inflight[i];
  end

  // Row 0 on the way into OUTPUT, the following row while presenting results.
  always_comb begin
    rd_idx = (state == OUTPUT) ? ROW_W'(out_idx + MW'(1)) : '0;
    for (int c = 0; c < N_SIZE; c++) rd_row[c*ACCW +: ACCW] = psum_buf[rd_idx][c];
  end

  for (genvar g = 0; g < N_SIZE; g++) begin : g_lane
    logic [DATAWIDTH-1:0] a_din;
    logic [ACCW-1:0]      b_din;

    assign a_din = a_fire ? a_in[g*DATAWIDTH +: DATAWIDTH] : '0;
    assign b_din = (a_fire && tile_q != '0) ? psum_buf[ROW_W'(row_cnt)][g] : '0;

    skew_delay_line #(.WIDTH(DATAWIDTH), .DEPTH(g + 1)) u_a (
      .clk(clk), .rst_n(rst_n), .din(a_din), .dout(matrix_A[g*DATAWIDTH +: DATAWIDTH])
    );
    skew_delay_line #(.WIDTH(ACCW), .DEPTH(B_OFS + g + 1)) u_b (
      .clk(clk), .rst_n(rst_n), .din(b_din), .dout(matrix_B[g*ACCW +: ACCW])
    );
    skew_delay_line #(.WIDTH($bits(tag_t)), .DEPTH(C_LAT + g + 1)) u_tag (
      .clk(clk), .rst_n(rst_n), .din(iss_tag), .dout(cap_tag[g])
    );
  end

  // Column c of a tagged row is valid on matrix_C when its tag emerges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int m = 0; m < M_MAX; m++)
        for (int c = 0; c < N_SIZE; c++) psum_buf[m][c] <= '0;
    end else begin
      for (int c = 0; c < N_SIZE; c++)
        if (cap_tag[c].valid) psum_buf[cap_tag[c].row_idx][c] <= matrix_C[c*ACCW +: ACCW];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
      valid_in <= 1'b0;
    end else begin
      inflight <= {inflight[PIPE-2:0], a_fire};
      valid_in <= v_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      wt_in_ready <= 1'b0;
      a_in_ready  <= 1'b0;
      wt_en       <= 1'b0;
      wt_flat     <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_last    <= 1'b0;
      m_q         <= '0;
      k_q         <= '0;
      tile_q      <= '0;
      row_cnt     <= '0;
      out_idx     <= '0;
    end else begin
      wt_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: if (start) begin
          m_q    <= cfg_m_rows;
          k_q    <= cfg_k_tiles;
          tile_q <= '0;
          busy   <= 1'b1;
          if (cfg_m_rows == '0 || cfg_k_tiles == '0) begin
            state <= FINISH;
          end else begin
            state       <= LOAD_W;
            wt_in_ready <= 1'b1;
          end
        end
        LOAD_W: if (wt_in_valid && wt_in_ready) begin
          wt_flat     <= wt_in;
          wt_en       <= 1'b1;
          wt_in_ready <= 1'b0;
          a_in_ready  <= 1'b1;
          row_cnt     <= '0;
          state       <= STREAM;
        end
        STREAM: if (a_fire) begin
          row_cnt <= row_cnt + MW'(1);
          if (row_cnt == m_q - MW'(1)) begin
            a_in_ready <= 1'b0;
            state      <= DRAIN;
          end
        end
        DRAIN: if (inflight == '0) begin
          if (tile_q < k_q - KW'(1)) begin
            tile_q      <= tile_q + KW'(1);
            wt_in_ready <= 1'b1;
            state       <= LOAD_W;
          end else begin
            res_valid <= 1'b1;
            res_data  <= rd_row;
            res_last  <= (m_q == MW'(1));
            out_idx   <= '0;
            state     <= OUTPUT;
          end
        end
        OUTPUT: if (res_ready) begin
          if (res_last) begin
            res_valid <= 1'b0;
            res_last  <= 1'b0;
            state     <= FINISH;
          end else begin
            out_idx  <= out_idx + MW'(1);
            res_data <= rd_row;
            res_last <= (out_idx + MW'(1) == m_q - MW'(1));
          end
        end
        FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_tile_sequencer.sv
// Bench for systolic_tile_sequencer with a behavioural weight-stationary array
// model on matrix_A/B/C and a matrix-multiply reference for job results.
module tb_systolic_tile_sequencer;

  localparam int DW    = 8;
  localparam int N     = 2;
  localparam int ACCW  = 24;
  localparam int C_LAT = 2;
  localparam int B_OFS = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [4:0] cfg_m_rows = '0;
  logic [4:0] cfg_k_tiles = '0;
  logic busy, done, wt_in_ready, a_in_ready, wt_en, valid_in, res_valid, res_last;
  logic wt_in_valid = 1'b0;
  logic a_in_valid = 1'b0;
  logic res_ready = 1'b0;
  logic [N*N*DW-1:0] wt_in = '0;
  logic [N*N*DW-1:0] wt_flat;
  logic [N*DW-1:0]   a_in = '0;
  logic [N*DW-1:0]   matrix_A;
  logic [N*ACCW-1:0] matrix_B, res_data;
  logic [N*ACCW-1:0] matrix_C = '0;

  always #5 clk = ~clk;

  systolic_tile_sequencer #(
    .DATAWIDTH(DW), .N_SIZE(N), .ACCW(ACCW), .M_MAX(16), .K_MAX(16),
    .B_OFS(B_OFS), .C_LAT(C_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_m_rows(cfg_m_rows),
    .cfg_k_tiles(cfg_k_tiles), .busy(busy), .done(done),
    .wt_in_valid(wt_in_valid), .wt_in_ready(wt_in_ready), .wt_in(wt_in),
    .a_in_valid(a_in_valid), .a_in_ready(a_in_ready), .a_in(a_in),
    .wt_en(wt_en), .wt_flat(wt_flat), .valid_in(valid_in),
    .matrix_A(matrix_A), .matrix_B(matrix_B), .matrix_C(matrix_C),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_last(res_last)
  );

  // Array model: column c result = B[c] + sum_r A[r]*W[r][c], with lane r of a
  // row seen at t+r, B[c] at t+B_OFS+c and the result presented at t+C_LAT+c.
  int cyc = 16;
  logic [DW-1:0]   ha [8][N];
  logic [ACCW-1:0] hb [8][N];
  logic [DW-1:0]   wm [N][N];
  always @(negedge clk) begin
    longint acc;
    int tb0;
    logic [N*ACCW-1:0] mc;
    for (int r = 0; r < N; r++) begin
      ha[cyc & 7][r] = matrix_A[r*DW +: DW];
      hb[cyc & 7][r] = matrix_B[r*ACCW +: ACCW];
    end
    if (wt_en)
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) wm[r][c] = wt_flat[(r*N+c)*DW +: DW];
    for (int c = 0; c < N; c++) begin
      tb0 = cyc - C_LAT - c;
      acc = longint'(hb[(tb0 + B_OFS + c) & 7][c]);
      for (int r = 0; r < N; r++)
        acc += longint'(ha[(tb0 + r) & 7][r]) * longint'(wm[r][c]);
      mc[c*ACCW +: ACCW] = ACCW'(acc);
    end
    matrix_C = mc;
    cyc++;
  end

  int hs_cnt = 0, done_cnt = 0, rv_cnt = 0;
  always @(posedge clk) begin
    if (res_valid && res_ready) hs_cnt++;
    if (done) done_cnt++;
    if (res_valid) rv_cnt++;
  end

  int checks = 0, failures = 0;
  int a_mat [16][32];
  int w_mat [32][N];
  int ex [16][N];

  typedef struct {
    int a0, a1, w00, w01, w10, w11, e0, e1;
  } vec_t;
  vec_t tbl [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_done"}, 64'(done), 0);
    chk({tag, "_ready"}, 64'({wt_in_ready, a_in_ready}), 0);
    chk({tag, "_wt"}, 64'({wt_en, wt_flat}), 0);
    chk({tag, "_arr"}, 64'({valid_in, matrix_A, matrix_B[23:0]}), 0);
    chk({tag, "_mb_hi"}, 64'(matrix_B[47:24]), 0);
    chk({tag, "_res"}, 64'({res_valid, res_last, res_data}), 0);
  endtask

  // Result = A (m x kN) * W (kN x N), wrapped to the psum width.
  task automatic compute_ref(input int m, input int k);
    for (int i = 0; i < m; i++)
      for (int c = 0; c < N; c++) begin
        int s = 0;
        for (int j = 0; j < k*N; j++) s += a_mat[i][j] * w_mat[j][c];
        ex[i][c] = s & 24'hFFFFFF;
      end
  endtask

  task automatic send_w(input int t);
    int n = 0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) wt_in[(r*N+c)*DW +: DW] = DW'(w_mat[t*N+r][c]);
    wt_in_valid = 1'b1;
    while (!wt_in_ready && n < 200) begin @(negedge clk); n++; end
    chk("wt_ready_wait", 64'(wt_in_ready), 1);
    @(negedge clk);
    wt_in_valid = 1'b0;
  endtask

  task automatic send_row(input int t, input int i, input int gap);
    int n = 0;
    if (gap == 1 && i > 0) begin a_in_valid = 1'b0; @(negedge clk); end
    if (gap == 2) repeat ($urandom_range(0, 2)) begin a_in_valid = 1'b0; @(negedge clk); end
    for (int r = 0; r < N; r++) a_in[r*DW +: DW] = DW'(a_mat[i][t*N+r]);
    a_in_valid = 1'b1;
    while (!a_in_ready && n < 200) begin @(negedge clk); n++; end
    chk("a_ready_wait", 64'(a_in_ready), 1);
    @(negedge clk);
    a_in_valid = 1'b0;
  endtask

  task automatic collect(input int m, input int bp, input string name);
    logic [N*ACCW-1:0] ev, held;
    for (int i = 0; i < m; i++) begin
      int n = 0;
      while (!res_valid && n < 500) begin @(negedge clk); n++; end
      chk({name, "_res_valid"}, 64'(res_valid), 1);
      held = res_data;
      repeat (bp) begin
        @(negedge clk);
        chk({name, "_bp_hold"}, 64'({res_valid, res_data}), 64'({1'b1, held}));
      end
      for (int c = 0; c < N; c++) ev[c*ACCW +: ACCW] = ACCW'(ex[i][c]);
      chk({name, "_res_data"}, 64'(res_data), 64'(ev));
      chk({name, "_res_last"}, 64'(res_last), 64'(i == m - 1));
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
    end
  endtask

  task automatic run_job(input int m, input int k, input int gap, input int bp, input string name);
    int hs0 = hs_cnt, d0 = done_cnt, rv0 = rv_cnt, n = 0;
    cfg_m_rows  = 5'(m);
    cfg_k_tiles = 5'(k);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({name, "_busy"}, 64'(busy), 1);
    if (m > 0 && k > 0) begin
      for (int t = 0; t < k; t++) begin
        send_w(t);
        for (int i = 0; i < m; i++) send_row(t, i, gap);
      end
      collect(m, bp, name);
    end
    while (busy && n < 200) begin @(negedge clk); n++; end
    chk({name, "_idle"}, 64'(busy), 0);
    @(negedge clk);
    chk({name, "_done_cnt"}, 64'(done_cnt - d0), 1);
    chk({name, "_rows"}, 64'(hs_cnt - hs0), 64'((k > 0) ? m : 0));
    if (m == 0 || k == 0) chk({name, "_no_res"}, 64'(rv_cnt - rv0), 0);
  endtask

  task automatic fill_4x4();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) a_mat[i][j] = i*4 + j + 1;
    for (int j = 0; j < 4; j++)
      for (int c = 0; c < N; c++) w_mat[j][c] = j*4 + c + 1;
    ex[0][0] = 90;  ex[0][1] = 100;
    ex[1][0] = 202; ex[1][1] = 228;
    ex[2][0] = 314; ex[2][1] = 356;
    ex[3][0] = 426; ex[3][1] = 484;
  endtask

  task automatic load_vec(input vec_t v);
    a_mat[0][0] = v.a0;  a_mat[0][1] = v.a1;
    w_mat[0][0] = v.w00; w_mat[0][1] = v.w01;
    w_mat[1][0] = v.w10; w_mat[1][1] = v.w11;
    ex[0][0] = v.e0;     ex[0][1] = v.e1;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{3, 4, 1, 2, 5, 6, 23, 30};
    tbl[1] = '{0, 0, 9, 9, 9, 9, 0, 0};
    tbl[2] = '{255, 255, 255, 255, 255, 255, 130050, 130050};
    tbl[3] = '{1, 0, 7, 8, 9, 10, 7, 8};
    tbl[4] = '{0, 2, 1, 1, 3, 4, 6, 8};

    start = 1'b1;
    cfg_m_rows = 5'd4;
    cfg_k_tiles = 5'd2;
    repeat (3) @(negedge clk);
    check_zero("reset");
    start = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_reset_busy", 64'(busy), 0);

    fill_4x4();
    run_job(4, 2, 0, 0, "full");
    run_job(4, 2, 1, 0, "gap");
    run_job(4, 2, 0, 3, "bp");

    for (int v = 0; v < 5; v++) begin
      load_vec(tbl[v]);
      run_job(1, 1, 0, 0, $sformatf("tbl%0d", v));
    end

    for (int it = 0; it < 6; it++) begin
      int m = int'($urandom_range(1, 6));
      int k = int'($urandom_range(1, 3));
      for (int i = 0; i < m; i++)
        for (int j = 0; j < k*N; j++) a_mat[i][j] = int'($urandom_range(0, 255));
      for (int j = 0; j < k*N; j++)
        for (int c = 0; c < N; c++) w_mat[j][c] = int'($urandom_range(0, 255));
      compute_ref(m, k);
      run_job(m, k, 2, int'($urandom_range(0, 2)), $sformatf("rnd%0d", it));
    end

    fill_4x4();
    cfg_m_rows = 5'd4;
    cfg_k_tiles = 5'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_w(0);
    for (int i = 0; i < 4; i++) send_row(0, i, 0);
    send_w(1);
    send_row(1, 0, 0);
    send_row(1, 1, 0);
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    load_vec(tbl[0]);
    run_job(1, 1, 0, 0, "post_rst");

    run_job(0, 1, 0, 0, "m_zero");
    run_job(3, 0, 0, 0, "k_zero");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
